// File: rtl/vrf_bank_arbiter.sv
// VRF bank arbiter: per-bank arbitration between operand-queue readers and
// VFU write-back requesters. Grants are combinational; writes win by default,
// a per-bank starvation counter forces a read through after StarveLimit
// consecutive write wins. Read data returns one cycle after the grant.
module vrf_bank_arbiter #(
  parameter int NumRd       = 3,
  parameter int NumWr       = 2,
  parameter int NrBank      = 8,
  parameter int AddrW       = 6,
  parameter int DataW       = 64,
  parameter int StarveLimit = 4,
  localparam int BW         = $clog2(NrBank),
  localparam int StrbW      = DataW / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic [NumRd-1:0]         rd_req_i,
  input  logic [NumRd*BW-1:0]      rd_bank_i,
  input  logic [NumRd*AddrW-1:0]   rd_addr_i,
  output logic [NumRd-1:0]         rd_gnt_o,

  input  logic [NumWr-1:0]         wr_req_i,
  input  logic [NumWr*BW-1:0]      wr_bank_i,
  input  logic [NumWr*AddrW-1:0]   wr_addr_i,
  input  logic [NumWr*DataW-1:0]   wr_data_i,
  input  logic [NumWr*StrbW-1:0]   wr_strb_i,
  output logic [NumWr-1:0]         wr_gnt_o,

  output logic [NrBank-1:0]        bank_req_o,
  output logic [NrBank-1:0]        bank_wen_o,
  output logic [NrBank*AddrW-1:0]  bank_addr_o,
  output logic [NrBank*DataW-1:0]  bank_wdata_o,
  output logic [NrBank*StrbW-1:0]  bank_wstrb_o,
  input  logic [NrBank*DataW-1:0]  bank_rdata_i,

  output logic [NumRd-1:0]         rd_valid_o,
  output logic [NumRd*DataW-1:0]   rd_data_o
);

  localparam int         RdPtrW    = (NumRd > 1) ? $clog2(NumRd) : 1;
  localparam int         WrPtrW    = (NumWr > 1) ? $clog2(NumWr) : 1;
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [RdPtrW-1:0] rd_ptr_q  [NrBank];
  logic [RdPtrW-1:0] rd_ptr_d  [NrBank];
  logic [WrPtrW-1:0] wr_ptr_q  [NrBank];
  logic [WrPtrW-1:0] wr_ptr_d  [NrBank];
  logic [3:0]        starve_q  [NrBank];
  logic [3:0]        starve_d  [NrBank];

  logic [NumRd-1:0]  rd_valid_q;
  logic [BW-1:0]     rd_bank_q [NumRd];
  logic [DataW-1:0]  rdata_arr [NrBank];

  // Per-bank arbitration: candidate selection, class priority, round-robin
  // winner search, bank port muxing and next-state of pointers/counters.
  always_comb begin : p_arb
    logic [NumRd-1:0]  rd_cand;
    logic [NumRd-1:0]  rd_oh;
    logic [NumWr-1:0]  wr_cand;
    logic [NumWr-1:0]  wr_oh;
    logic              rd_found;
    logic              wr_found;
    logic              wr_win;
    logic [RdPtrW-1:0] rd_ptr_nxt;
    logic [WrPtrW-1:0] wr_ptr_nxt;
    logic [AddrW-1:0]  sel_addr;
    logic [DataW-1:0]  sel_wdata;
    logic [StrbW-1:0]  sel_wstrb;

    rd_gnt_o     = '0;
    wr_gnt_o     = '0;
    bank_req_o   = '0;
    bank_wen_o   = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_wstrb_o = '0;
    rd_cand      = '0;
    rd_oh        = '0;
    wr_cand      = '0;
    wr_oh        = '0;
    rd_found     = 1'b0;
    wr_found     = 1'b0;
    wr_win       = 1'b0;
    rd_ptr_nxt   = '0;
    wr_ptr_nxt   = '0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_wstrb    = '0;
    for (int b = 0; b < NrBank; b++) begin
      rd_ptr_d[b] = rd_ptr_q[b];
      wr_ptr_d[b] = wr_ptr_q[b];
      starve_d[b] = starve_q[b];
    end

    for (int b = 0; b < NrBank; b++) begin
      for (int k = 0; k < NumRd; k++) begin
        rd_cand[k] = rd_req_i[k] && (rd_bank_i[k*BW +: BW] == BW'(b));
      end
      for (int j = 0; j < NumWr; j++) begin
        wr_cand[j] = wr_req_i[j] && (wr_bank_i[j*BW +: BW] == BW'(b));
      end

      // Writes win unless a read has been passed over StarveLimit times.
      wr_win = (|wr_cand) && (~|rd_cand || (starve_q[b] < StarveMax));

      // Round-robin search: first indices at/after the pointer, then wrap.
      rd_oh      = '0;
      rd_found   = 1'b0;
      rd_ptr_nxt = rd_ptr_q[b];
      for (int k = 0; k < NumRd; k++) begin
        if (!rd_found && rd_cand[k] && (k >= int'(rd_ptr_q[b]))) begin
          rd_found   = 1'b1;
          rd_oh[k]   = 1'b1;
          rd_ptr_nxt = (k == NumRd - 1) ? '0 : RdPtrW'(k + 1);
        end
      end
      for (int k = 0; k < NumRd; k++) begin
        if (!rd_found && rd_cand[k]) begin
          rd_found   = 1'b1;
          rd_oh[k]   = 1'b1;
          rd_ptr_nxt = (k == NumRd - 1) ? '0 : RdPtrW'(k + 1);
        end
      end

      wr_oh      = '0;
      wr_found   = 1'b0;
      wr_ptr_nxt = wr_ptr_q[b];
      for (int j = 0; j < NumWr; j++) begin
        if (!wr_found && wr_cand[j] && (j >= int'(wr_ptr_q[b]))) begin
          wr_found   = 1'b1;
          wr_oh[j]   = 1'b1;
          wr_ptr_nxt = (j == NumWr - 1) ? '0 : WrPtrW'(j + 1);
        end
      end
      for (int j = 0; j < NumWr; j++) begin
        if (!wr_found && wr_cand[j]) begin
          wr_found   = 1'b1;
          wr_oh[j]   = 1'b1;
          wr_ptr_nxt = (j == NumWr - 1) ? '0 : WrPtrW'(j + 1);
        end
      end

      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      if (wr_win) begin
        for (int j = 0; j < NumWr; j++) begin
          if (wr_oh[j]) begin
            sel_addr  = wr_addr_i[j*AddrW +: AddrW];
            sel_wdata = wr_data_i[j*DataW +: DataW];
            sel_wstrb = wr_strb_i[j*StrbW +: StrbW];
          end
        end
        wr_gnt_o      = wr_gnt_o | wr_oh;
        wr_ptr_d[b]   = wr_ptr_nxt;
        bank_req_o[b] = 1'b1;
        bank_wen_o[b] = 1'b1;
      end else if (rd_found) begin
        for (int k = 0; k < NumRd; k++) begin
          if (rd_oh[k]) begin
            sel_addr = rd_addr_i[k*AddrW +: AddrW];
          end
        end
        rd_gnt_o      = rd_gnt_o | rd_oh;
        rd_ptr_d[b]   = rd_ptr_nxt;
        bank_req_o[b] = 1'b1;
      end

      bank_addr_o[b*AddrW +: AddrW]  = sel_addr;
      bank_wdata_o[b*DataW +: DataW] = sel_wdata;
      bank_wstrb_o[b*StrbW +: StrbW] = sel_wstrb;

      // A write can only beat a waiting read while below the limit, so the
      // increment saturates at StarveLimit by construction.
      starve_d[b] = ((|rd_cand) && wr_win) ? (starve_q[b] + 4'd1) : 4'd0;
    end
  end

  // Round-robin pointers and starvation counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NrBank; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
        starve_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NrBank; b++) begin
        rd_ptr_q[b] <= rd_ptr_d[b];
        wr_ptr_q[b] <= wr_ptr_d[b];
        starve_q[b] <= starve_d[b];
      end
    end
  end

  // Read-return tracking: remember which bank each granted reader hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= '0;
      for (int k = 0; k < NumRd; k++) begin
        rd_bank_q[k] <= '0;
      end
    end else begin
      rd_valid_q <= rd_gnt_o;
      for (int k = 0; k < NumRd; k++) begin
        if (rd_gnt_o[k]) begin
          rd_bank_q[k] <= rd_bank_i[k*BW +: BW];
        end
      end
    end
  end

  // Unpack bank read data for indexed selection.
  always_comb begin
    for (int b = 0; b < NrBank; b++) begin
      rdata_arr[b] = bank_rdata_i[b*DataW +: DataW];
    end
  end

  // Route the registered bank's data to each reader; zero when not valid.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NumRd; k++) begin
      if (rd_valid_q[k]) begin
        rd_data_o[k*DataW +: DataW] = rdata_arr[rd_bank_q[k]];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Bench for vrf_bank_arbiter (default parameters): table of per-cycle
// vectors with hand-derived grants, read returns tracked in a queue.
module tb_vrf_bank_arbiter;

  logic         clk_i;
  logic         rst_ni;
  logic [2:0]   rd_req_i;
  logic [8:0]   rd_bank_i;
  logic [17:0]  rd_addr_i;
  logic [2:0]   rd_gnt_o;
  logic [1:0]   wr_req_i;
  logic [5:0]   wr_bank_i;
  logic [11:0]  wr_addr_i;
  logic [127:0] wr_data_i;
  logic [15:0]  wr_strb_i;
  logic [1:0]   wr_gnt_o;
  logic [7:0]   bank_req_o;
  logic [7:0]   bank_wen_o;
  logic [47:0]  bank_addr_o;
  logic [511:0] bank_wdata_o;
  logic [63:0]  bank_wstrb_o;
  logic [511:0] bank_rdata_i;
  logic [2:0]   rd_valid_o;
  logic [191:0] rd_data_o;

  logic [31:0]  cyc = '0;
  int           n_cmp;
  int           n_err;

  vrf_bank_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_req_i     (rd_req_i),
    .rd_bank_i    (rd_bank_i),
    .rd_addr_i    (rd_addr_i),
    .rd_gnt_o     (rd_gnt_o),
    .wr_req_i     (wr_req_i),
    .wr_bank_i    (wr_bank_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_strb_i    (wr_strb_i),
    .wr_gnt_o     (wr_gnt_o),
    .bank_req_o   (bank_req_o),
    .bank_wen_o   (bank_wen_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_wstrb_o (bank_wstrb_o),
    .bank_rdata_i (bank_rdata_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 32'd1;

  // Bank read data changes every cycle so a stale or early return is visible.
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      bank_rdata_i[b*64 +: 64] = {8'hB0 + 8'(b), 24'h0, cyc};
    end
  end

  function automatic logic [63:0] rdata_of(input int b);
    return {8'hB0 + 8'(b), 24'h0, cyc};
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  rd_req;
    logic [8:0]  rd_bank;
    logic [1:0]  wr_req;
    logic [5:0]  wr_bank;
    logic [2:0]  exp_rg;
    logic [1:0]  exp_wg;
    logic [7:0]  exp_breq;
    logic [7:0]  exp_bwen;
    int          chk_bank;
    logic [5:0]  exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
  } vec_t;

  typedef struct {
    logic [2:0] valid;
    logic [8:0] banks;
  } ret_t;

  vec_t vecs[$];
  ret_t sb[$];

  task automatic add(input string nm, input logic [2:0] rr, input logic [8:0] rb,
                     input logic [1:0] wr, input logic [5:0] wb,
                     input logic [2:0] erg, input logic [1:0] ewg,
                     input logic [7:0] ebr, input logic [7:0] ebw, input int cb,
                     input logic [5:0] ea, input logic [63:0] ed, input logic [7:0] es);
    vec_t v;
    v.name = nm;       v.rd_req = rr;     v.rd_bank = rb;
    v.wr_req = wr;     v.wr_bank = wb;    v.exp_rg = erg;
    v.exp_wg = ewg;    v.exp_breq = ebr;  v.exp_bwen = ebw;
    v.chk_bank = cb;   v.exp_addr = ea;   v.exp_wdata = ed;
    v.exp_wstrb = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_ret(input logic [2:0] valid, input logic [8:0] banks);
    ret_t r;
    r.valid = valid;
    r.banks = banks;
    sb.push_back(r);
  endtask

  task automatic check_return(input string nm);
    ret_t r;
    logic [63:0] ed;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.sb_empty: got no expected entry, expected one", nm);
      return;
    end
    r = sb.pop_front();
    chk($sformatf("%s.rd_valid", nm), 128'(rd_valid_o), 128'(r.valid));
    for (int k = 0; k < 3; k++) begin
      ed = r.valid[k] ? rdata_of(int'(r.banks[k*3 +: 3])) : 64'h0;
      chk($sformatf("%s.rd_data%0d", nm, k), 128'(rd_data_o[k*64 +: 64]), 128'(ed));
    end
  endtask

  initial begin
    vec_t v;
    logic idle_bad;
    n_cmp     = 0;
    n_err     = 0;
    rst_ni    = 1'b0;
    rd_req_i  = '0;
    rd_bank_i = '0;
    wr_req_i  = '0;
    wr_bank_i = '0;
    rd_addr_i = {6'h12, 6'h11, 6'h10};
    wr_addr_i = {6'd6, 6'd5};
    wr_data_i = {64'hCD, 64'hAB};
    wr_strb_i = {8'h80, 8'h01};

    //   name          rd_req  rd_bank             wr_req wr_bank       rg      wg     breq   bwen   bk addr   wdata   wstrb
    add("idle",        3'b000, {3'd3,3'd3,3'd3}, 2'b00, {3'd3,3'd3}, 3'b000, 2'b00, 8'h00, 8'h00, 3, 6'h00, 64'h0,  8'h00);
    add("rr_a",        3'b011, {3'd3,3'd3,3'd3}, 2'b00, {3'd3,3'd3}, 3'b001, 2'b00, 8'h08, 8'h00, 3, 6'h10, 64'h0,  8'h00);
    add("rr_b",        3'b011, {3'd3,3'd3,3'd3}, 2'b00, {3'd3,3'd3}, 3'b010, 2'b00, 8'h08, 8'h00, 3, 6'h11, 64'h0,  8'h00);
    add("rr_c",        3'b011, {3'd3,3'd3,3'd3}, 2'b00, {3'd3,3'd3}, 3'b001, 2'b00, 8'h08, 8'h00, 3, 6'h10, 64'h0,  8'h00);
    add("rr_d",        3'b011, {3'd3,3'd3,3'd3}, 2'b00, {3'd3,3'd3}, 3'b010, 2'b00, 8'h08, 8'h00, 3, 6'h11, 64'h0,  8'h00);
    add("wr_over_rd",  3'b001, {3'd2,3'd2,3'd2}, 2'b01, {3'd2,3'd2}, 3'b000, 2'b01, 8'h04, 8'h04, 2, 6'd5,  64'hAB, 8'h01);
    add("rd_after_wr", 3'b001, {3'd2,3'd2,3'd2}, 2'b00, {3'd2,3'd2}, 3'b001, 2'b00, 8'h04, 8'h00, 2, 6'h10, 64'h0,  8'h00);
    add("multi_bank",  3'b011, {3'd0,3'd4,3'd0}, 2'b10, {3'd7,3'd0}, 3'b011, 2'b10, 8'h91, 8'h80, 7, 6'd6,  64'hCD, 8'h80);
    add("b2b_a",       3'b100, {3'd5,3'd5,3'd5}, 2'b00, {3'd5,3'd5}, 3'b100, 2'b00, 8'h20, 8'h00, 5, 6'h12, 64'h0,  8'h00);
    add("b2b_b",       3'b100, {3'd5,3'd5,3'd5}, 2'b00, {3'd5,3'd5}, 3'b100, 2'b00, 8'h20, 8'h00, 5, 6'h12, 64'h0,  8'h00);
    add("rr3_a",       3'b111, {3'd6,3'd6,3'd6}, 2'b00, {3'd6,3'd6}, 3'b001, 2'b00, 8'h40, 8'h00, 6, 6'h10, 64'h0,  8'h00);
    add("rr3_b",       3'b111, {3'd6,3'd6,3'd6}, 2'b00, {3'd6,3'd6}, 3'b010, 2'b00, 8'h40, 8'h00, 6, 6'h11, 64'h0,  8'h00);
    add("rr3_c",       3'b111, {3'd6,3'd6,3'd6}, 2'b00, {3'd6,3'd6}, 3'b100, 2'b00, 8'h40, 8'h00, 6, 6'h12, 64'h0,  8'h00);
    add("rr3_wrap",    3'b111, {3'd6,3'd6,3'd6}, 2'b00, {3'd6,3'd6}, 3'b001, 2'b00, 8'h40, 8'h00, 6, 6'h10, 64'h0,  8'h00);
    add("wr_rr_a",     3'b000, {3'd1,3'd1,3'd1}, 2'b11, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("wr_rr_b",     3'b000, {3'd1,3'd1,3'd1}, 2'b11, {3'd1,3'd1}, 3'b000, 2'b10, 8'h02, 8'h02, 1, 6'd6,  64'hCD, 8'h80);
    add("starve_w1",   3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("starve_w2",   3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("starve_w3",   3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("starve_w4",   3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("starve_rd",   3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b100, 2'b00, 8'h02, 8'h00, 1, 6'h12, 64'h0,  8'h00);
    add("starve_clr",  3'b100, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);
    add("wr_only",     3'b000, {3'd1,3'd1,3'd1}, 2'b01, {3'd1,3'd1}, 3'b000, 2'b01, 8'h02, 8'h02, 1, 6'd5,  64'hAB, 8'h01);

    // Reset state; combinational grants still work while held in reset.
    #2;
    rd_req_i  = 3'b010;
    rd_bank_i = {3'd0, 3'd2, 3'd0};
    #1;
    chk("reset.rd_valid", 128'(rd_valid_o), 128'(3'b000));
    chk("reset.rd_data", 128'(rd_data_o[127:0]), 128'h0);
    chk("reset.rd_gnt", 128'(rd_gnt_o), 128'(3'b010));
    chk("reset.bank_req", 128'(bank_req_o), 128'(8'h04));
    @(posedge clk_i);
    #1;
    chk("reset.held_valid", 128'(rd_valid_o), 128'(3'b000));
    rd_req_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_ret(3'b000, 9'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk_i);
      #1;
      check_return((i == 0) ? "post_reset" : vecs[i-1].name);
      rd_req_i  = v.rd_req;
      rd_bank_i = v.rd_bank;
      wr_req_i  = v.wr_req;
      wr_bank_i = v.wr_bank;
      #1;
      chk($sformatf("%s.rd_gnt", v.name), 128'(rd_gnt_o), 128'(v.exp_rg));
      chk($sformatf("%s.wr_gnt", v.name), 128'(wr_gnt_o), 128'(v.exp_wg));
      chk($sformatf("%s.bank_req", v.name), 128'(bank_req_o), 128'(v.exp_breq));
      chk($sformatf("%s.bank_wen", v.name), 128'(bank_wen_o), 128'(v.exp_bwen));
      chk($sformatf("%s.addr", v.name), 128'(bank_addr_o[v.chk_bank*6 +: 6]), 128'(v.exp_addr));
      chk($sformatf("%s.wdata", v.name), 128'(bank_wdata_o[v.chk_bank*64 +: 64]), 128'(v.exp_wdata));
      chk($sformatf("%s.wstrb", v.name), 128'(bank_wstrb_o[v.chk_bank*8 +: 8]), 128'(v.exp_wstrb));
      idle_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (!v.exp_breq[b]) begin
          idle_bad = idle_bad | (|bank_addr_o[b*6 +: 6]) | (|bank_wdata_o[b*64 +: 64])
                     | (|bank_wstrb_o[b*8 +: 8]) | bank_wen_o[b];
        end
      end
      chk($sformatf("%s.idle_zero", v.name), 128'(idle_bad), 128'(1'b0));
      push_ret(v.exp_rg, v.rd_bank);
    end

    // Reset in the middle of operation drops the in-flight return.
    @(posedge clk_i);
    #1;
    check_return(vecs[vecs.size()-1].name);
    rd_req_i  = 3'b010;
    rd_bank_i = {3'd3, 3'd3, 3'd3};
    wr_req_i  = '0;
    #1;
    chk("rsq.pre_gnt", 128'(rd_gnt_o), 128'(3'b010));
    push_ret(3'b010, {3'd3, 3'd3, 3'd3});
    @(posedge clk_i);
    #1;
    check_return("rsq.pre");
    rd_req_i  = 3'b001;
    rd_bank_i = {3'd0, 3'd0, 3'd0};
    #1;
    chk("rsq.gnt_rd0", 128'(rd_gnt_o), 128'(3'b001));
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rsq.async_clr", 128'(rd_valid_o), 128'(3'b000));
    chk("rsq.comb_in_rst", 128'(rd_gnt_o), 128'(3'b001));
    @(posedge clk_i);
    #1;
    chk("rsq.drop_inflight", 128'(rd_valid_o), 128'(3'b000));
    chk("rsq.drop_data", 128'(rd_data_o[127:0]), 128'h0);
    rd_req_i = '0;
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rsq.no_late_valid", 128'(rd_valid_o), 128'(3'b000));
    rd_req_i  = 3'b011;
    rd_bank_i = {3'd0, 3'd0, 3'd0};
    #1;
    chk("rsq.ptr_cleared", 128'(rd_gnt_o), 128'(3'b001));
    push_ret(3'b001, {3'd0, 3'd0, 3'd0});
    @(posedge clk_i);
    #1;
    check_return("rsq.post");
    rd_req_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vrf_bank_arbiter.md
VRF_BANK_ARBITER -- requirements
Module: vrf_bank_arbiter

Interface
REQ-001 SHALL have parameter NumRd, default 3, number of operand-queue read requesters.
REQ-002 SHALL have parameter NumWr, default 2, number of VFU write-back requesters.
REQ-003 SHALL have parameter NrBank, default 8, number of VRF banks (power of two); BW = $clog2(NrBank).
REQ-004 SHALL have parameter AddrW, default 6, bank-local address width; DataW, default 64; StarveLimit, default 4 (range 1..15).
REQ-005 SHALL have ports clk_i input 1 clock; rst_ni input 1 asynchronous active-low reset.
REQ-006 SHALL have rd_req_i input NumRd, rd_bank_i input NumRd x BW, rd_addr_i input NumRd x AddrW, rd_gnt_o output NumRd.
REQ-007 SHALL have wr_req_i input NumWr, wr_bank_i input NumWr x BW, wr_addr_i input NumWr x AddrW, wr_data_i input NumWr x DataW, wr_strb_i input NumWr x DataW/8, wr_gnt_o output NumWr.
REQ-008 SHALL have bank_req_o, bank_wen_o outputs NrBank; bank_addr_o output NrBank x AddrW; bank_wdata_o output NrBank x DataW; bank_wstrb_o output NrBank x DataW/8; bank_rdata_i input NrBank x DataW.
REQ-009 SHALL have rd_valid_o output NumRd; rd_data_o output NumRd x DataW.

Function
REQ-010 Grants SHALL be combinational, same cycle as request; requester holds req and payload stable until granted.
REQ-011 Per bank b, candidates = requesters with req high and bank field == b; at most one grant per bank per cycle.
REQ-012 Default priority SHALL be writes over reads: if any write candidate and starve_cnt[b] < StarveLimit, grant one write; else grant one read if any.
REQ-013 When starve_cnt[b] == StarveLimit and a read candidate exists, a read SHALL win over pending writes.
REQ-014 starve_cnt[b] (4 bits): +1 when a read candidate exists but a write is granted; cleared when a read is granted or no read candidate exists; never exceeds StarveLimit.
REQ-015 Within a class, round-robin per bank: separate rd_ptr[b] and wr_ptr[b]; search starts at ptr index ascending with wrap; after grant to index k, ptr <= (k+1) mod N; unchanged otherwise.
REQ-016 Granted write: bank_req_o[b]=1, bank_wen_o[b]=1, addr/wdata/wstrb from winner.
REQ-017 Granted read: bank_req_o[b]=1, bank_wen_o[b]=0, addr from winner, wdata/wstrb = 0.
REQ-018 Idle bank: bank_req_o, bank_wen_o, addr, wdata, wstrb all 0.
REQ-019 Read latency: rd_valid_o[k] SHALL assert exactly one cycle after rd_gnt_o[k], with rd_data_o[k] = bank_rdata_i[registered bank of that grant]; rd_data_o = 0 when rd_valid_o low.
REQ-020 Back-to-back grants to one reader on consecutive cycles SHALL give rd_valid_o high on consecutive cycles, no bubbles; no return backpressure exists.
REQ-021 Requests to different banks in the same cycle SHALL all be granted.

Reset
REQ-022 On rst_ni low, asynchronously: rd_valid_o=0, all rd_ptr/wr_ptr=0, all starve_cnt=0.
REQ-023 Reset mid-operation SHALL drop any read return in flight (no rd_valid_o after deassertion for pre-reset grants).
REQ-024 Combinational outputs during reset SHALL follow REQ-010..018 with reset-state pointers and counters.

Verification
REQ-025 rd0 and rd1 both to bank 3 for 4 cycles, no writes -> grants rd0,rd1,rd0,rd1; rd_valid_o matching, 1 cycle later.
REQ-026 wr0 bank 2 addr 5 data 0xAB strb 0x01 with rd0 bank 2 -> wr0 granted, bank_wen_o[2]=1, bank_addr_o[2]=5; rd0 waits.
REQ-027 wr0 held continuously to bank 1 with rd2 to bank 1, StarveLimit=4 -> 4 write grants, read granted cycle 5, starve_cnt back to 0.
REQ-028 rd0 bank 0, rd1 bank 4, wr1 bank 7 same cycle -> all three granted; next cycle rd_valid_o=3'b011.
REQ-029 rd0 granted, rst_ni pulsed low before next edge -> rd_valid_o stays 0; next rd0/rd1 contention on the same bank grants rd0 first.
